// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for one router output channel. Each entry carries
// a start-of-packet tag; optional sticky error flags are enabled by ROUTER_FIFO_ERR_FLAGS_EN.
module router_pkt_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int LEN_MSB     = 7,
    parameter int LEN_LSB     = 2,
    parameter int AFULL_LEVEL = 14
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          soft_reset,
    input  logic                          write_enb,
    input  logic                          sof_in,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          read_enb,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic                          rd_last,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic [$clog2(DEPTH):0]        count
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    ,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          len_err
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LENW = LEN_MSB - LEN_LSB + 1;
    localparam int RW   = LENW + 2;
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LEVEL);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [RW-1:0]       remaining;
    logic [DATA_WIDTH:0] rd_entry;
    logic                clear;
    logic                do_write;
    logic                do_read;
    logic                rd_sof;

    always_comb begin
        count       = wr_ptr - rd_ptr;
        empty       = (wr_ptr == rd_ptr);
        full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        almost_full = (count >= AFULL_CNT);
    end

    assign clear    = !resetn || soft_reset;
    assign do_write = !clear && write_enb && !full;
    assign do_read  = !clear && read_enb && !empty;
    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign rd_sof   = rd_entry[DATA_WIDTH];

    // No reset on the array so it maps onto RAM; empty gating hides stale words.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= {sof_in, data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            remaining  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr     <= rd_ptr + 1'b1;
                data_out   <= rd_entry[DATA_WIDTH-1:0];
                data_valid <= 1'b1;
                if (rd_sof) begin
                    // Header length counts payload bytes; +1 covers the trailing parity byte.
                    remaining <= {2'b00, rd_entry[LEN_MSB:LEN_LSB]} + RW'(1);
                    rd_last   <= 1'b0;
                end else begin
                    rd_last <= (remaining == RW'(1));
                    if (remaining != '0) begin
                        remaining <= remaining - RW'(1);
                    end
                end
            end else begin
                data_valid <= 1'b0;
                rd_last    <= 1'b0;
            end
        end
    end

`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            if (write_enb && full) begin
                overflow <= 1'b1;
            end
            if (read_enb && empty) begin
                underflow <= 1'b1;
            end
            // A new header while bytes are still owed means the previous packet was cut short.
            if (do_read && rd_sof && (remaining != '0)) begin
                len_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
- Parametrised, packet-aware synchronous FIFO for one output channel of the 1x3 router; next generation of the per-channel router FIFO.
- Width, depth and header length-field position are parameters. Each entry stores a start-of-packet tag bit alongside the data.
- Adds occupancy count, almost-full flag, registered read-valid/last-byte strobes and packet-boundary tracking.
- Sits between the router synchroniser/FSM (write side) and the output port read logic.

Parameters:
DATA_WIDTH, 8, data byte width (>=4)
DEPTH, 16, entry count; power of two, >=4
LEN_MSB, 7, MSB of payload-length field within a header byte
LEN_LSB, 2, LSB of payload-length field within a header byte
AFULL_LEVEL, 14, occupancy at or above which almost_full asserts (1..DEPTH)

Ports:
clock  in  1  clock, rising edge
resetn  in  1  reset; synchronous, active-low
soft_reset  in  1  synchronous flush, active-high
write_enb  in  1  write request
sof_in  in  1  tags the word written this cycle as a packet header; same-cycle aligned with write_enb
data_in  in  DATA_WIDTH  write data
read_enb  in  1  read request
data_out  out  DATA_WIDTH  registered read data
data_valid  out  1  data_out holds a word popped on the previous edge
rd_last  out  1  with data_valid: word is final byte (parity) of its packet
empty  out  1  occupancy == 0
full  out  1  occupancy == DEPTH
almost_full  out  1  occupancy >= AFULL_LEVEL
count  out  log2(DEPTH)+1  current occupancy

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1). Bit DATA_WIDTH holds the SOF tag. Pointers are log2(DEPTH)+1 bits wide, and the extra MSB gives wrap parity.
- empty is true when pointers are equal. full is true when the pointer MSBs differ and the low bits are equal. count = wr_ptr - rd_ptr, modulo 2^(AW+1). All flags are combinational from pointers.
- Write: on an edge with write_enb && !full, store {sof_in, data_in} at wr_ptr[AW-1:0] and increment wr_ptr. A write while full is ignored; storage and pointers are unchanged.
- Read: on an edge with read_enb && !empty, data_out <= entry data, data_valid <= 1 and rd_ptr is incremented. Latency is one clock from the read_enb edge. If there is no pop, data_valid <= 0 and data_out holds its value. Tri-state values are never driven.
- Simultaneous read and write: both occur independently in the same edge.
  - When full, the read proceeds and the write is dropped (full is evaluated before the edge).
  - When empty, the write proceeds and the read is ignored.
  - count is unchanged when both succeed.
- Packet tracking uses a remaining counter, LEN_MSB-LEN_LSB+3 bits wide.
  - Popping a SOF-tagged entry loads remaining <= len + 1, where len = data[LEN_MSB:LEN_LSB] (payload plus parity byte).
  - Popping an untagged entry with remaining > 0 decrements remaining.
  - rd_last is registered alongside data_valid. It is 1 when the popped entry is untagged and remaining == 1 before the edge.
  - An untagged pop with remaining == 0 (orphan byte) is delivered with rd_last = 0 and leaves remaining at 0.
  - A header with len = 0 yields a two-word packet: header then parity.
- Reset (resetn low at an edge) overrides everything:
  - Pointers, remaining, data_out, data_valid and rd_last all go to 0.
  - Flags read empty=1, full=0, almost_full=0, count=0.
  - Memory contents are not cleared.
  - Reset applies mid-packet with no residue.
- soft_reset (with resetn high) has the same effect as reset, except memory is untouched. It takes priority over simultaneous read and write. A write presented in the soft_reset cycle is discarded.
- Memory is not reset, so the RAM is inferable. Stale contents are never observable, because reads are gated by empty.

Optional Feature:
ROUTER_FIFO_ERR_FLAGS_EN
- Defined: adds sticky outputs overflow (write_enb && full at an edge) and underflow (read_enb && empty at an edge), plus len_err.
  - len_err sets when a SOF-tagged entry is popped while remaining != 0, meaning the previous packet was truncated.
  - All three clear only on resetn or soft_reset.
- Not defined: these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, data_out=0, data_valid=0 for 5 cycles.
- Write header 8'h0C with sof_in=1, then 8'h11, 8'h22, 8'h33, parity 8'h1E; then read 5 cycles -> data_out sequence 0C,11,22,33,1E one clock after each read_enb, data_valid=1 each cycle, rd_last=1 only with 1E.
- Write 16 words 8'h00..8'h0F with read_enb held low -> almost_full rises at count=14, full at count=16. A 17th write of 8'hFF is dropped. Reading all 16 returns 00..0F in order, then empty=1.
- With full, assert write_enb and read_enb together for 1 cycle, data 8'hAA -> count stays 15 after the cycle, 8'hAA is not stored, and the first word is popped.
- Preload 20 words across wrap (writes and reads interleaved, 3 in-flight) -> output order is exact and count never exceeds 16; the pointer MSB toggle is exercised.
- Mid-packet (header 8'h08, one payload byte read), assert soft_reset with write_enb=1 -> next cycle empty=1, count=0, data_valid=0, rd_last=0. With ROUTER_FIFO_ERR_FLAGS_EN, overflow, underflow and len_err are all 0.
